fir_param: RTL and testbench



---
 rtl/fir_pkg.sv | 44 ++++
 rtl/fir_round_sat.sv | 46 ++++
 rtl/fir_param.sv | 145 ++++++++++++++
 tb/tb_fir_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the parametrised FIR filter family.
//   clog2     : ceiling log2 usable in constant expressions
//   prod_w    : product width for a DW x CW multiply
//   acc_w     : accumulator width that cannot overflow for TAPS products
//   LATENCY   : fixed sample-to-output latency in clock edges
//   FIR_PW / FIR_AW / acc_t : widths and accumulator type for the default
//                             13-bit, 8-tap configuration
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int LATENCY = 3;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Sum of TAPS products of width PW grows by at most clog2(TAPS) bits.
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  localparam int FIR_DEF_TAPS = 8;
  localparam int FIR_DEF_DW   = 13;
  localparam int FIR_DEF_CW   = 13;
  localparam int FIR_PW       = prod_w(FIR_DEF_DW, FIR_DEF_CW);
  localparam int FIR_AW       = acc_w(FIR_DEF_DW, FIR_DEF_CW, FIR_DEF_TAPS);

  typedef logic signed [FIR_AW-1:0] acc_t;

endpackage

// File: rtl/fir_round_sat.sv
// -----------------------------------------------------------------------------
// fir_round_sat
// Combinational requantiser: round-half-up arithmetic right shift by FRAC,
// then saturate to a signed OW-bit result.
//   acc  in  AW  signed full-precision sum
//   dout out OW  signed rounded/saturated value
//   ovf  out 1   saturation was applied
// -----------------------------------------------------------------------------
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int AW   = 29,
  parameter int OW   = 13,
  parameter int FRAC = 12
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [OW-1:0] dout,
  output logic                 ovf
);

  // One guard bit above AW absorbs the rounding carry; the extra width over
  // OW keeps the saturation limits representable for any OW.
  localparam int XW = (AW + 1 > OW + 1) ? AW + 1 : OW + 1;
  localparam logic signed [XW-1:0] HALF = XW'(1) <<< (FRAC - 1);
  localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (OW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -(XW'(1) <<< (OW - 1));

  logic signed [XW-1:0] acc_x;
  logic signed [XW-1:0] r;

  always_comb begin
    acc_x = XW'(acc);
    r     = (acc_x + HALF) >>> FRAC;
    if (r > MAXV) begin
      dout = MAXV[OW-1:0];
      ovf  = 1'b1;
    end else if (r < MINV) begin
      dout = MINV[OW-1:0];
      ovf  = 1'b1;
    end else begin
      dout = r[OW-1:0];
      ovf  = 1'b0;
    end
  end

endmodule

// File: rtl/fir_param.sv
// -----------------------------------------------------------------------------
// fir_param
// Parametrised direct-form FIR filter with register-loaded coefficients and a
// fixed three-stage pipeline (multiply, sum, requantise).
//   CLK        in  1      clock, all state on rising edge
//   RST_n      in  1      asynchronous active-low reset, clears everything
//   VIN        in  1      input sample valid; advances the delay line
//   DIN        in  DW     signed input sample
//   FLUSH      in  1      clears delay line and valid pipeline, drops VIN
//   COEF_WE    in  1      coefficient write enable
//   COEF_ADDR  in  clog2  coefficient index, 0 = newest sample tap
//   COEF_DATA  in  CW     signed coefficient
//   DOUT       out OW     signed filtered output, held while VOUT=0
//   VOUT       out 1      output valid, three edges after the sample edge
//   OVF        out 1      saturation on this output (qualified by VOUT)
// -----------------------------------------------------------------------------
module fir_param
  import fir_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int DW   = 13,
  parameter int CW   = 13,
  parameter int OW   = 13,
  parameter int FRAC = 12,
  localparam int ADDR_W = (clog2(TAPS) < 1) ? 1 : clog2(TAPS)
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 VIN,
  input  logic signed [DW-1:0] DIN,
  input  logic                 FLUSH,
  input  logic                 COEF_WE,
  input  logic [ADDR_W-1:0]    COEF_ADDR,
  input  logic signed [CW-1:0] COEF_DATA,
  output logic signed [OW-1:0] DOUT,
  output logic                 VOUT,
  output logic                 OVF
);

  localparam int PW = prod_w(DW, CW);
  localparam int AW = acc_w(DW, CW, TAPS);

  logic signed [DW-1:0] x_q [TAPS];
  logic signed [DW-1:0] x_d [TAPS];
  logic signed [CW-1:0] h_q [TAPS];
  logic signed [CW-1:0] h_d [TAPS];
  logic signed [PW-1:0] p_q [TAPS];
  logic signed [PW-1:0] p_d [TAPS];
  logic signed [AW-1:0] acc_q, acc_d;
  // vld_q[0]: sample in delay line, [1]: products valid, [2]: sum valid
  logic [LATENCY-1:0]   vld_q, vld_d;
  logic                 vout_q, vout_d;
  logic signed [OW-1:0] dout_q, dout_d;
  logic                 ovf_q, ovf_d;

  logic signed [OW-1:0] rs_dout;
  logic                 rs_ovf;

  // Delay line: FLUSH has priority so a coincident sample is dropped.
  always_comb begin
    x_d = x_q;
    if (FLUSH) begin
      for (int i = 0; i < TAPS; i++) x_d[i] = '0;
    end else if (VIN) begin
      x_d[0] = DIN;
      for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
    end
  end

  // Address decode by comparison so indices >= TAPS simply match nothing.
  always_comb begin
    h_d = h_q;
    for (int i = 0; i < TAPS; i++) begin
      if (COEF_WE && (COEF_ADDR == ADDR_W'(i))) h_d[i] = COEF_DATA;
    end
  end

  // S1: per-tap products from the delay line and coefficients as they stand
  // after the sample edge, so a write on the sample edge is already visible.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      always_comb begin
        p_d[gi] = PW'(x_q[gi]) * PW'(h_q[gi]);
      end
    end
  endgenerate

  // S2: full-precision sum.
  always_comb begin
    acc_d = '0;
    for (int i = 0; i < TAPS; i++) acc_d = acc_d + AW'(p_q[i]);
  end

  fir_round_sat #(
    .AW   (AW),
    .OW   (OW),
    .FRAC (FRAC)
  ) u_round_sat (
    .acc  (acc_q),
    .dout (rs_dout),
    .ovf  (rs_ovf)
  );

  // Valid pipeline never stalls; FLUSH discards everything in flight while
  // DOUT/OVF keep their previous values.
  always_comb begin
    vld_d  = FLUSH ? '0 : {vld_q[LATENCY-2:0], VIN};
    vout_d = FLUSH ? 1'b0 : vld_q[LATENCY-1];
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (!FLUSH && vld_q[LATENCY-1]) begin
      dout_d = rs_dout;
      ovf_d  = rs_ovf;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
        p_q[i] <= '0;
      end
      acc_q  <= '0;
      vld_q  <= '0;
      vout_q <= 1'b0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      h_q    <= h_d;
      p_q    <= p_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_fir_param.sv
// -----------------------------------------------------------------------------
// tb_fir_param
// Self-checking bench for fir_param (default 8 taps, 13-bit data/coef/out).
// A reference model keeps the sample history and coefficient values as plain
// integers, computes each output with integer arithmetic when the sample is
// accepted, and schedules it for the edge three cycles later.
// -----------------------------------------------------------------------------
module tb_fir_param;

  localparam int TAPS = 8;
  localparam int DW   = 13;
  localparam int CW   = 13;
  localparam int OW   = 13;
  localparam int FRAC = 12;
  localparam int LAT  = 3;

  logic                 CLK = 1'b0;
  logic                 RST_n = 1'b0;
  logic                 VIN = 1'b0;
  logic signed [DW-1:0] DIN = '0;
  logic                 FLUSH = 1'b0;
  logic                 COEF_WE = 1'b0;
  logic [2:0]           COEF_ADDR = '0;
  logic signed [CW-1:0] COEF_DATA = '0;
  logic signed [OW-1:0] DOUT;
  logic                 VOUT;
  logic                 OVF;

  fir_param #(
    .TAPS (TAPS),
    .DW   (DW),
    .CW   (CW),
    .OW   (OW),
    .FRAC (FRAC)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .VIN       (VIN),
    .DIN       (DIN),
    .FLUSH     (FLUSH),
    .COEF_WE   (COEF_WE),
    .COEF_ADDR (COEF_ADDR),
    .COEF_DATA (COEF_DATA),
    .DOUT      (DOUT),
    .VOUT      (VOUT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    int val;
    bit ovf;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  int   hist [TAPS];
  int   h_m  [TAPS];
  exp_t pend [$];
  int   cap  [$];
  int   last_dout = 0;

  int imp_ref [8] = '{63, 125, 188, 250, 313, 375, 438, 500};

  task automatic ck(input string tag, input logic signed [63:0] got,
                    input logic signed [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      h_m[i]  = 0;
    end
    pend.delete();
    last_dout = 0;
  endtask

  // y = round_half_up(sum(x*h) / 2^FRAC), then clamp to OW signed bits.
  task automatic calc(output int val, output bit ovf);
    longint s;
    longint r;
    longint maxv;
    longint minv;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(hist[i]) * longint'(h_m[i]);
    r    = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -(longint'(1) <<< (OW - 1));
    if (r > maxv) begin
      val = int'(maxv);
      ovf = 1'b1;
    end else if (r < minv) begin
      val = int'(minv);
      ovf = 1'b1;
    end else begin
      val = int'(r);
      ovf = 1'b0;
    end
  endtask

  // One clock: drive inputs, apply the edge to the model, check outputs.
  task automatic cyc(input bit vin, input int din, input bit flush,
                     input bit we, input int addr, input int data);
    exp_t e;
    int   v;
    bit   o;
    VIN       = vin;
    DIN       = DW'(din);
    FLUSH     = flush;
    COEF_WE   = we;
    COEF_ADDR = 3'(addr);
    COEF_DATA = CW'(data);
    @(posedge CLK);
    cycle++;
    if (we && addr < TAPS) h_m[addr] = int'(COEF_DATA);
    if (flush) begin
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
      pend.delete();
    end else if (vin) begin
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(DIN);
      calc(v, o);
      pend.push_back('{due: cycle + LAT, val: v, ovf: o});
    end
    #1;
    if (pend.size() > 0 && pend[0].due == cycle) begin
      e = pend.pop_front();
      ck("vout", VOUT, 1);
      ck("dout", DOUT, e.val);
      ck("ovf", OVF, e.ovf);
      last_dout = e.val;
      cap.push_back(int'(DOUT));
    end else begin
      ck("vout_idle", VOUT, 0);
      ck("dout_hold", DOUT, last_dout);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_coefs(input int base, input bit ramp);
    for (int i = 0; i < TAPS; i++) cyc(0, 0, 0, 1, i, ramp ? base * (i + 1) : base);
  endtask

  task automatic check_impulse(input string tag);
    ck({tag, "_count"}, cap.size(), 8);
    for (int i = 0; i < 8; i++) ck(tag, (i < cap.size()) ? cap[i] : 0, imp_ref[i]);
  endtask

  initial begin
    model_reset();

    // Reset state
    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    ck("rst_dout", DOUT, 0);
    ck("rst_vout", VOUT, 0);
    ck("rst_ovf", OVF, 0);
    RST_n = 1'b1;

    // Impulse response with h[i] = 256*(i+1)
    load_coefs(256, 1);
    cap.delete();
    cyc(1, 1000, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0);
    idle(5);
    check_impulse("imp");

    // Same impulse with two idle cycles between samples
    cap.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1, (i == 0) ? 1000 : 0, 0, 0, 0, 0);
      idle(2);
    end
    idle(4);
    check_impulse("imp_gap");

    // Positive then negative saturation
    load_coefs(4095, 0);
    cap.delete();
    for (int i = 0; i < 8; i++) cyc(1, 4095, 0, 0, 0, 0);
    idle(4);
    ck("sat_pos", (cap.size() == 8) ? cap[7] : 0, 4095);
    cap.delete();
    for (int i = 0; i < 8; i++) cyc(1, -4096, 0, 0, 0, 0);
    idle(4);
    ck("sat_neg", (cap.size() == 8) ? cap[7] : 0, -4096);

    // Coefficient write on the same edge as sample 4
    for (int i = 0; i < TAPS; i++) cyc(0, 0, 0, 1, i, (i == 0) ? 2048 : 0);
    cap.delete();
    for (int i = 0; i < 9; i++) cyc(1, 100, 0, (i == 4), 0, 0);
    idle(4);
    ck("cupd_count", cap.size(), 9);
    for (int i = 0; i < 9; i++)
      ck("cupd", (i < cap.size()) ? cap[i] : 0, (i < 4) ? 50 : 0);

    // FLUSH with coincident VIN, then a clean impulse
    load_coefs(256, 1);
    for (int i = 0; i < 5; i++) cyc(1, int'($urandom_range(0, 8191)) - 4096, 0, 0, 0, 0);
    cyc(1, 1234, 1, 0, 0, 0);
    idle(4);
    cap.delete();
    cyc(1, 1000, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0);
    idle(4);
    check_impulse("flush_imp");

    // Randomised traffic: gaps, coefficient writes, occasional flush
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 9) < 7),
          int'($urandom_range(0, 8191)) - 4096,
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, TAPS - 1)),
          int'($urandom_range(0, 8191)) - 4096);
    end
    idle(4);

    // Reset while outputs are active
    load_coefs(256, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1000, 0, 0, 0, 0);
    ck("pre_rst_vout", VOUT, 1);
    RST_n = 1'b0;
    #1;
    ck("arst_dout", DOUT, 0);
    ck("arst_vout", VOUT, 0);
    ck("arst_ovf", OVF, 0);
    model_reset();
    #2;
    RST_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1, int'($urandom_range(0, 8191)) - 4096, 0, 0, 0, 0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
